instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the single-cycle RISC-V core. It owns the program counter and runs the request/ready handshake with instruction memory. It presents one held, valid instruction at a time to the decode path, which drives `inst[6:0]` into `main_control`. It also applies branch/jump redirects from the execute stage.

## Interface
- `XLEN`, 32, PC and address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `NOP_INST`, 32'h0000_0013, instruction driven when no valid instruction (addi x0,x0,0)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  XLEN  fetch address; equals `pc`
- `imem_rdata`  in  32  instruction word, sampled when `imem_req && imem_ready`
- `imem_ready`  in  1  memory accepts request and returns data this cycle
- `stall`  in  1  downstream cannot consume the held instruction
- `redirect_valid`  in  1  branch/JAL taken; load `redirect_pc`
- `redirect_pc`  in  XLEN  target address
- `inst_valid`  out  1  `inst` holds a fetched instruction
- `inst`  out  32  held instruction, `NOP_INST` when not valid
- `opcode`  out  7  `inst[6:0]`, feeds main control
- `pc`  out  XLEN  address of current/held instruction
- `pc_plus4`  out  XLEN  `pc + 4`, wraps modulo 2^XLEN
- `fetch_err`  out  1  one-cycle pulse on misaligned redirect
- `fetch_count`  out  32  number of instructions consumed, wraps

## Operation
- Reset (async assert, sync-released use):
  - state IDLE, `pc`=RESET_PC, `inst`=NOP_INST, `inst_valid`=0
  - `imem_req`=0, `fetch_err`=0, `fetch_count`=0
- FSM states IDLE, FETCH, VALID:
  - IDLE: `imem_req`=0; next cycle -> FETCH unconditionally.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`: latch `inst`<=`imem_rdata`, `inst_valid`<=1, -> VALID. Otherwise stay; `imem_req` stays high.
  - VALID: `imem_req`=0, `inst`/`pc` held.
    - `stall`=1: hold indefinitely.
    - `stall`=0: `pc`<=`pc`+4, `inst_valid`<=0, `inst`<=NOP_INST, `fetch_count`+=1, -> FETCH.
- Redirect (`redirect_valid`=1) has priority over everything in FETCH and VALID:
  - `pc`<=`{redirect_pc[XLEN-1:2],2'b00}`, `inst_valid`<=0, `inst`<=NOP_INST, -> FETCH.
  - A coincident `imem_ready` response is discarded.
  - `fetch_count` increments if the state was VALID. `stall` is ignored.
- Redirect in IDLE is ignored.
- Misalignment: `redirect_valid && redirect_pc[1:0]!=0` -> `fetch_err`=1 next cycle for exactly one cycle. The aligned address is still taken.
- `imem_addr` may change while `imem_req` is high only via redirect. No outstanding-transaction state exists.

## Timing
- Best-case throughput: one instruction per 2 cycles (FETCH with ready, then VALID with no stall).
- Latency: `inst_valid` rises on the edge after the `imem_ready` cycle.
- Memory wait states add one cycle each in FETCH.
- `opcode`, `pc_plus4` and `imem_addr` are combinational from registers; no input-to-output combinational path.
- `rst_n` low mid-fetch: outputs take their reset values immediately (async), including `imem_req`=0.

## Test plan
- Reset release, `imem_ready`=1, memory returns 32'h00500093 at 0: `imem_req`=1 at cycle 1. `inst_valid`=1, `opcode`=7'b0010011, `pc`=0 at cycle 2. `pc`=4 request at cycle 3.
- 3 wait states (`imem_ready` low 3 cycles): `imem_req` held high with `imem_addr` stable. Instruction valid exactly 1 cycle after ready. `fetch_count` unchanged until consumed.
- `stall`=1 for 5 cycles in VALID: `inst`, `pc` and `inst_valid` constant, `imem_req`=0. Release -> `pc`+4 and `fetch_count`+1.
- `redirect_valid` with `redirect_pc`=0x100 during FETCH coincident with `imem_ready`: data discarded, `inst`=0x13, `inst_valid`=0, next request at 0x100.
- Redirect to 0x102: `pc`=0x100, `fetch_err` high for exactly one cycle.
- `rst_n` pulsed low while in FETCH at `pc`=0x20: `pc`=RESET_PC, `imem_req`=0, `fetch_count`=0 immediately. Fetch restarts via IDLE.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode-side outputs and redirect inputs.
// The master side is the fetch stage; the slave side is memory/decode/execute (or a bench).
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_err;
  logic [31:0]     fetch_count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, opcode, pc, pc_plus4, fetch_err, fetch_count,
    input  imem_rdata, imem_ready, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, opcode, pc, pc_plus4, fetch_err, fetch_count,
    output imem_rdata, imem_ready, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per request, holds it for decode,
// applies execute-stage redirects. One instruction per two cycles best case; stall holds VALID.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  fetch_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fetch_err_q, fetch_err_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic [XLEN-1:0] redirect_aligned;
  logic            redirect_take;

  assign redirect_aligned = {fetch_if.redirect_pc[XLEN-1:2], 2'b00};
  // Redirects only mean something once the stage is running.
  assign redirect_take    = fetch_if.redirect_valid && (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_valid_d  = inst_valid_q;
    fetch_count_d = fetch_count_q;
    fetch_err_d   = redirect_take && (fetch_if.redirect_pc[1:0] != 2'b00);

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_take) begin
          // A response arriving with the redirect belongs to the wrong path.
          pc_d         = redirect_aligned;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
        end else if (fetch_if.imem_ready) begin
          inst_d       = fetch_if.imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = VALID;
        end
      end
      VALID: begin
        if (redirect_take) begin
          pc_d          = redirect_aligned;
          inst_d        = NOP_INST;
          inst_valid_d  = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = FETCH;
        end else if (!fetch_if.stall) begin
          pc_d          = pc_q + XLEN'(4);
          inst_d        = NOP_INST;
          inst_valid_d  = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= NOP_INST;
      inst_valid_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_valid_q  <= inst_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_if.imem_req    = (state_q == FETCH);
  assign fetch_if.imem_addr   = pc_q;
  assign fetch_if.inst_valid  = inst_valid_q;
  assign fetch_if.inst        = inst_q;
  assign fetch_if.opcode      = inst_q[6:0];
  assign fetch_if.pc          = pc_q;
  assign fetch_if.pc_plus4    = pc_q + XLEN'(4);
  assign fetch_if.fetch_err   = fetch_err_q;
  assign fetch_if.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes expected deliveries, a monitor pops on each new valid instruction.
module tb_instr_fetch;
  logic clk;
  logic rst_n;

  instr_fetch_if #(.XLEN(32)) bus ();

  instr_fetch #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fetch_if(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word 0 is addi x1,x0,5; every other address returns {addr[24:0],7'h33}.
  assign bus.imem_rdata = (bus.imem_addr == 32'h0) ? 32'h0050_0093 : {bus.imem_addr[24:0], 7'h33};

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.inst = inst; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: each rising inst_valid is one delivered instruction.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %0h inst %0h with nothing expected", bus.pc, bus.inst);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_pc", bus.pc, e.pc);
          check("sb_inst", bus.inst, e.inst);
          check("sb_opcode", {25'd0, bus.opcode}, {25'd0, e.inst[6:0]});
          check("sb_count", bus.fetch_count, e.cnt);
        end
      end
      prev_valid = bus.inst_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n              = 1'b0;
    bus.imem_ready     = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (2) tick();
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'h13);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_pc4", bus.pc_plus4, 32'h4);
    check("rst_cnt", bus.fetch_count, 32'h0);
    check("rst_err", {31'd0, bus.fetch_err}, 32'd0);

    rst_n = 1'b1;
    check("idle_req", {31'd0, bus.imem_req}, 32'd0);
    push(32'h0, 32'h0050_0093, 32'd0);
    tick();                                   // cycle 1: FETCH at 0
    check("c1_req", {31'd0, bus.imem_req}, 32'd1);
    check("c1_addr", bus.imem_addr, 32'h0);
    tick();                                   // cycle 2: VALID
    check("c2_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("c2_opcode", {25'd0, bus.opcode}, 32'h13);
    check("c2_req", {31'd0, bus.imem_req}, 32'd0);
    tick();                                   // cycle 3: FETCH at 4
    check("c3_req", {31'd0, bus.imem_req}, 32'd1);
    check("c3_addr", bus.imem_addr, 32'h4);
    check("c3_cnt", bus.fetch_count, 32'd1);

    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_req", {31'd0, bus.imem_req}, 32'd1);
      check("ws_addr", bus.imem_addr, 32'h4);
      check("ws_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("ws_cnt", bus.fetch_count, 32'd1);
    end
    bus.imem_ready = 1'b1;
    push(32'h4, 32'h0000_0233, 32'd1);
    tick();
    check("ws_done_valid", {31'd0, bus.inst_valid}, 32'd1);

    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_inst", bus.inst, 32'h0000_0233);
      check("stall_pc", bus.pc, 32'h4);
      check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_pc", bus.pc, 32'h8);
    check("unstall_cnt", bus.fetch_count, 32'd2);
    check("unstall_inst", bus.inst, 32'h13);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();                                   // redirect wins over coincident ready
    bus.redirect_valid = 1'b0;
    check("rd_inst", bus.inst, 32'h13);
    check("rd_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rd_addr", bus.imem_addr, 32'h100);
    check("rd_req", {31'd0, bus.imem_req}, 32'd1);
    check("rd_cnt", bus.fetch_count, 32'd2);
    check("rd_err", {31'd0, bus.fetch_err}, 32'd0);
    push(32'h100, 32'h0000_8033, 32'd2);
    tick();

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    bus.stall          = 1'b1;
    tick();                                   // misaligned redirect from VALID
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    bus.imem_ready     = 1'b0;
    check("mis_pc", bus.pc, 32'h100);
    check("mis_err1", {31'd0, bus.fetch_err}, 32'd1);
    check("mis_cnt", bus.fetch_count, 32'd3);
    check("mis_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    check("mis_err2", {31'd0, bus.fetch_err}, 32'd0);
    tick();
    check("mis_err3", {31'd0, bus.fetch_err}, 32'd0);
    bus.imem_ready = 1'b1;
    push(32'h100, 32'h0000_8033, 32'd3);
    tick();
    bus.imem_ready = 1'b0;
    tick();
    check("adv_pc", bus.pc, 32'h104);
    check("adv_pc4", bus.pc_plus4, 32'h108);
    check("adv_cnt", bus.fetch_count, 32'd4);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    tick();
    bus.redirect_valid = 1'b0;
    check("pre_rst_pc", bus.pc, 32'h20);
    check("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);

    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'h0);
    check("arst_req", {31'd0, bus.imem_req}, 32'd0);
    check("arst_cnt", bus.fetch_count, 32'd0);
    check("arst_inst", bus.inst, 32'h13);
    tick();
    rst_n          = 1'b1;
    bus.imem_ready = 1'b1;
    check("restart_idle", {31'd0, bus.imem_req}, 32'd0);
    push(32'h0, 32'h0050_0093, 32'd0);
    tick();
    check("restart_req", {31'd0, bus.imem_req}, 32'd1);
    check("restart_addr", bus.imem_addr, 32'h0);
    tick();
    check("restart_valid", {31'd0, bus.inst_valid}, 32'd1);
    bus.stall = 1'b1;
    repeat (2) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
